tis_stream_source: RTL
======================

Name: tis_stream_source

Overview:
- Writer end of the inter-node port channel that each core reads through its `rready*`/`left`/`right`/`up`/`down` inputs.
- Host loads a list of 11-bit signed values, then issues `start`; the block presents them one at a time to a core port and advances only when the core consumes each word.
- Acts as a TIS input node (IN.x) feeding a core in system benches and in the top level.

Parameters:
- DEPTH, 16, number of stored values; must be a power of 2 and at most 256.
- WIDTH, 11, data width in bits; signed two's complement, same as core acc.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- clr  input  1  synchronous clear: return to LOAD, len=0, idx=0, sent_count=0
- ld_valid  input  1  host load strobe
- ld_data  input  WIDTH  host value to store (signed)
- ld_ready  output  1  load accepted this cycle when ld_valid=1
- start  input  1  begin or replay emission
- out_data  output  WIDTH  current word presented to the core port
- out_valid  output  1  out_data is valid (core sees this as its rready for that direction)
- out_read  input  1  core consumes out_data this cycle
- sent_count  output  8  words transferred since clr, saturating at 255
- done  output  1  all len words emitted

Behaviour:
- Reset (async, rst=1):
  - state=LOAD; len=0; idx=0; sent_count=0.
  - ld_ready=1, out_valid=0, out_data=0, done=0.
  - Memory contents are don't-care.
- Storage:
  - mem[0..DEPTH-1], len (0..DEPTH), idx (0..DEPTH-1).
  - Reads are non-destructive, which allows replay.
- Load clamping: stored value = clamp(ld_data, -999, +999). For example, 1023 stores 999 and -1024 stores -999.
- State LOAD:
  - ld_ready = (len != DEPTH).
  - When ld_valid && ld_ready: mem[len] <= clamped value; len++.
  - When len==DEPTH: ld_valid is ignored and nothing is written.
  - On start: go to RUN with idx=0 if the post-update len > 0, otherwise go to DONE. A load in the same cycle as start counts.
  - out_valid=0 and done=0 throughout LOAD.
- State RUN:
  - out_valid=1; out_data=mem[idx] (combinational from the registered idx, so it is valid the first cycle after start).
  - ld_ready=0.
  - Transfer occurs when out_valid && out_read.
  - On transfer: sent_count++ (saturating at 255).
  - On transfer with idx==len-1: go to DONE. Otherwise idx++.
  - out_read while out_valid=0 has no effect.
  - Back-to-back transfers run at 1 word per cycle.
- State DONE:
  - out_valid=0; done=1; ld_ready=0.
  - start: go to RUN with idx=0 (replay); sent_count keeps counting.
- start in RUN is ignored.
- clr has priority over start, ld_valid and out_read in every state.
  - A transfer in the same cycle as clr is not counted.
- rst mid-RUN: out_valid drops immediately (async).
- out_data is 0 whenever out_valid=0 (registered zero, not stale memory).

Optional Feature:
- TIS_SRC_LOOP_EN
  - Defined: a transfer with idx==len-1 wraps idx to 0 and stays in RUN. done never asserts; sent_count still saturates at 255.
  - Not defined: the block stops in DONE as described in Behaviour.

Test Plan:
- Reset release; load 3, -7, 999; start; out_read held 1 -> out_data 3, -7, 999 on consecutive cycles; done=1 on the 4th cycle; sent_count=3.
- Load 1023 and -1024 -> emitted as 999 and -999 (clamping).
- Load DEPTH+2 values -> ld_ready=0 once len=16; the extra two values are dropped; exactly 16 words are emitted.
- Load 5, 6; start; toggle out_read 1,0,0,1 -> out_data holds 6 during the stall cycles; done only after the second transfer.
- start with len=0 -> DONE next cycle, out_valid never 1. clr in the same cycle as a transfer -> LOAD, sent_count=0.
- Loop mode with 2 values and out_read=1 for 6 cycles -> output sequence a,b,a,b,a,b; done=0. Without the macro -> output a,b, then done=1.

Source files
------------

// File: rtl/tis_stream_source.sv
// TIS input node: host loads clamped signed words, then streams them to a core port.
// Ports: clk, rst, clr, ld_valid/ld_data/ld_ready, start, out_data/out_valid/out_read,
// sent_count, done. Optional macro TIS_SRC_LOOP_EN makes emission wrap and never finish.
module tis_stream_source #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_read,
  output logic [7:0]       sent_count,
  output logic             done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic signed [WIDTH-1:0] VMAX = WIDTH'(999);
  localparam logic signed [WIDTH-1:0] VMIN = WIDTH'(-999);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    len, len_n;
  logic [AW-1:0]    idx, idx_n;
  logic [7:0]       cnt, cnt_n;
  logic             wr_en;
  logic             last;

  logic signed [WIDTH-1:0] sd;
  logic signed [WIDTH-1:0] clamped;

  assign sd = $signed(ld_data);

  always_comb begin
    clamped = sd;
    if (sd > VMAX) clamped = VMAX;
    else if (sd < VMIN) clamped = VMIN;
  end

  assign last = (LW'(idx) == (len - LW'(1)));

  always_ff @(posedge clk) begin
    if (wr_en) mem[len[AW-1:0]] <= clamped;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
      len   <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      len   <= len_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    len_n     = len;
    idx_n     = idx;
    cnt_n     = cnt;
    wr_en     = 1'b0;
    ld_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_LOAD: begin
        ld_ready = (len != LW'(DEPTH));
        wr_en    = ld_valid && ld_ready;
        if (wr_en) len_n = len + LW'(1);
        // a word loaded alongside start is part of the run
        if (start) begin
          idx_n   = '0;
          state_n = (len_n != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        out_valid = 1'b1;
        if (out_read) begin
          if (cnt != 8'hFF) cnt_n = cnt + 8'd1;
          if (last) begin
            idx_n = '0;
`ifdef TIS_SRC_LOOP_EN
            state_n = S_RUN;
`else
            state_n = S_DONE;
`endif
          end else begin
            idx_n = idx + AW'(1);
          end
        end
      end
      S_DONE: begin
`ifdef TIS_SRC_LOOP_EN
        done = 1'b0;
`else
        done = 1'b1;
`endif
        // replay needs something stored to replay
        if (start && len != '0) begin
          idx_n   = '0;
          state_n = S_RUN;
        end
      end
      default: state_n = S_LOAD;
    endcase
    if (clr) begin
      state_n = S_LOAD;
      len_n   = '0;
      idx_n   = '0;
      cnt_n   = '0;
      wr_en   = 1'b0;
    end
  end

  assign out_data   = (state == S_RUN) ? mem[idx] : '0;
  assign sent_count = cnt;

endmodule
